// File: rtl/modulo_divisor_frequencia_prog_if.sv
// Control/status bundle of the programmable frequency divider.
// The master side drives enable and divisor requests; the slave side is the divider.
interface modulo_divisor_frequencia_prog_if #(
  parameter int WIDTH = 20
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] div_value;
  logic             mode_in;
  logic             clk_div;
  logic             tick;
  logic [WIDTH-1:0] count;
  logic             pending;
  logic             err;

  modport master (
    output en, load, div_value, mode_in,
    input  clk_div, tick, count, pending, err
  );

  modport slave (
    input  en, load, div_value, mode_in,
    output clk_div, tick, count, pending, err
  );
endinterface

// File: rtl/modulo_divisor_frequencia_prog.sv
// Programmable synchronous divider: one counter divides clk by N and produces a square
// wave or one-cycle pulse plus a period tick; N/mode changes only land at period boundaries.
module modulo_divisor_frequencia_prog #(
  parameter int WIDTH        = 20,
  parameter int DEFAULT_DIV  = 16384,
  parameter int DEFAULT_MODE = 0
) (
  input logic                            clk,
  input logic                            clr,
  modulo_divisor_frequencia_prog_if.slave bus
);

  localparam logic [WIDTH-1:0] DIV_RST  = WIDTH'(DEFAULT_DIV);
  localparam logic             MODE_RST = 1'(DEFAULT_MODE);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic             mode_q, mode_d;
  logic             pend_mode_q, pend_mode_d;
  logic             pend_q, pend_d;
  logic             clk_div_q, clk_div_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;

  logic load_ok;
  logic wrap;
  logic boundary;
  logic changed;

  always_comb begin
    load_ok  = bus.load && (bus.div_value >= WIDTH'(2));
    wrap     = bus.en && (cnt_q == (div_q - WIDTH'(1)));
    // A stopped counter is as safe a place to switch N/mode as a wrap edge.
    boundary = wrap || !bus.en;
    changed  = boundary && (load_ok || pend_q);

    cnt_d       = cnt_q;
    div_d       = div_q;
    mode_d      = mode_q;
    pend_d      = pend_q;
    pend_div_d  = pend_div_q;
    pend_mode_d = pend_mode_q;
    tick_d      = wrap;
    err_d       = bus.load && !load_ok;

    if (boundary && load_ok) begin
      div_d  = bus.div_value;
      mode_d = bus.mode_in;
      pend_d = 1'b0;
    end else if (boundary && pend_q) begin
      div_d  = pend_div_q;
      mode_d = pend_mode_q;
      pend_d = 1'b0;
    end else if (load_ok) begin
      pend_div_d  = bus.div_value;
      pend_mode_d = bus.mode_in;
      pend_d      = 1'b1;
    end

    if (bus.en) begin
      cnt_d = wrap ? '0 : cnt_q + WIDTH'(1);
    end else if (changed) begin
      cnt_d = '0;
    end

    // Square output is derived from the post-edge count and divisor so that
    // clk_div == (count >= N/2) holds in every cycle, including right after a switch.
    if (bus.en) begin
      clk_div_d = mode_d ? tick_d : (cnt_d >= (div_d >> 1));
    end else if (changed) begin
      clk_div_d = 1'b0;
    end else begin
      clk_div_d = clk_div_q;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_q       <= '0;
      div_q       <= DIV_RST;
      mode_q      <= MODE_RST;
      pend_q      <= 1'b0;
      pend_div_q  <= DIV_RST;
      pend_mode_q <= MODE_RST;
      clk_div_q   <= 1'b0;
      tick_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      mode_q      <= mode_d;
      pend_q      <= pend_d;
      pend_div_q  <= pend_div_d;
      pend_mode_q <= pend_mode_d;
      clk_div_q   <= clk_div_d;
      tick_q      <= tick_d;
      err_q       <= err_d;
    end
  end

  assign bus.clk_div = clk_div_q;
  assign bus.tick    = tick_q;
  assign bus.count   = cnt_q;
  assign bus.pending = pend_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_modulo_divisor_frequencia_prog.sv
// Self-checking bench for the programmable divider: directed scenarios with spec-derived
// expectations plus randomized traffic against a cycle-level behavioural model.
module tb_modulo_divisor_frequencia_prog;

  localparam int WIDTH   = 20;
  localparam int DEF_DIV = 16384;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  modulo_divisor_frequencia_prog_if #(.WIDTH(WIDTH)) bus ();

  modulo_divisor_frequencia_prog #(
    .WIDTH(WIDTH), .DEFAULT_DIV(DEF_DIV), .DEFAULT_MODE(0)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_cnt, m_div, m_pdiv;
  bit m_mode, m_pmode, m_pend, m_clkdiv, m_tick, m_err;

  logic [WIDTH+3:0] dvec;
  assign dvec = {bus.clk_div, bus.tick, bus.pending, bus.err, bus.count};

  function automatic logic [WIDTH+3:0] mvec();
    return {m_clkdiv, m_tick, m_pend, m_err, WIDTH'(m_cnt)};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_div = DEF_DIV; m_mode = 0; m_pend = 0;
    m_pdiv = DEF_DIV; m_pmode = 0; m_clkdiv = 0; m_tick = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit ok;
    ok    = bus.load && (int'(bus.div_value) >= 2);
    m_err = bus.load && !ok;
    if (bus.en) begin
      if (m_cnt == m_div - 1) begin
        m_cnt = 0; m_tick = 1;
        if (ok) begin
          m_div = int'(bus.div_value); m_mode = bus.mode_in; m_pend = 0;
        end else if (m_pend) begin
          m_div = m_pdiv; m_mode = m_pmode; m_pend = 0;
        end
      end else begin
        m_cnt++; m_tick = 0;
        if (ok) begin
          m_pdiv = int'(bus.div_value); m_pmode = bus.mode_in; m_pend = 1;
        end
      end
      m_clkdiv = m_mode ? m_tick : (m_cnt >= m_div / 2);
    end else begin
      m_tick = 0;
      if (ok) begin
        m_div = int'(bus.div_value); m_mode = bus.mode_in; m_pend = 0;
        m_cnt = 0; m_clkdiv = 0;
      end else if (m_pend) begin
        m_div = m_pdiv; m_mode = m_pmode; m_pend = 0;
        m_cnt = 0; m_clkdiv = 0;
      end
    end
  endtask

  // Advance one clock edge, model first, then sample 1 ns after the edge.
  task automatic cycle();
    if (!clr) model_reset(); else model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int dv, input bit md);
    bus.load = 1'b1; bus.div_value = WIDTH'(dv); bus.mode_in = md;
    cycle();
    bus.load = 1'b0;
  endtask

  task automatic test_reset();
    #2 clr = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      bus.en = i[0];
      cycle();
      checks++;
      if (dvec !== '0) begin
        errors++;
        $display("FAIL reset_hold i=%0d outputs=%h expected=0", i, dvec);
      end
    end
    clr = 1'b1;
  endtask

  task automatic test_default();
    int first_rise = 0, first_fall = 0, tick1 = 0, tick2 = 0, bad = 0;
    bit prev = 1'b0;
    bus.en = 1'b1;
    for (int k = 1; k <= 32770; k++) begin
      cycle();
      if (bus.clk_div && !prev && first_rise == 0) first_rise = k;
      if (!bus.clk_div && prev && first_fall == 0) first_fall = k;
      if (bus.tick) begin
        if (tick1 == 0) tick1 = k; else if (tick2 == 0) tick2 = k;
      end
      prev = bus.clk_div;
      if (dvec !== mvec()) bad++;
    end
    checks++;
    if (first_rise !== 8192) begin errors++; $display("FAIL default_rise edge=%0d expected=8192", first_rise); end
    checks++;
    if (first_fall !== 16384) begin errors++; $display("FAIL default_fall edge=%0d expected=16384", first_fall); end
    checks++;
    if (tick1 !== 16384) begin errors++; $display("FAIL default_tick1 edge=%0d expected=16384", tick1); end
    checks++;
    if (tick2 !== 32768) begin errors++; $display("FAIL default_tick2 edge=%0d expected=32768", tick2); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL default_model mismatches=%0d expected=0", bad); end
  endtask

  task automatic test_odd();
    bus.en = 1'b0;
    do_load(5, 1'b0);
    checks++;
    if (bus.count !== 0 || bus.pending !== 1'b0 || bus.clk_div !== 1'b0) begin
      errors++;
      $display("FAIL odd_apply count=%0d pending=%b clk_div=%b expected 0/0/0", bus.count, bus.pending, bus.clk_div);
    end
    bus.en = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      cycle();
      checks++;
      if (bus.count !== WIDTH'(k % 5) || bus.clk_div !== ((k % 5) >= 2) || bus.tick !== ((k % 5) == 0)) begin
        errors++;
        $display("FAIL odd_pattern k=%0d count=%0d clk_div=%b tick=%b expected %0d/%b/%b",
                 k, bus.count, bus.clk_div, bus.tick, k % 5, (k % 5) >= 2, (k % 5) == 0);
      end
    end
  endtask

  task automatic test_midchange();
    int edges;
    bus.en = 1'b0;
    do_load(10, 1'b0);
    bus.en = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    do_load(4, 1'b0);
    checks++;
    if (bus.pending !== 1'b1 || bus.count !== 4) begin
      errors++;
      $display("FAIL mid_stage pending=%b count=%0d expected 1/4", bus.pending, bus.count);
    end
    edges = 4;
    while (!bus.tick && edges < 30) begin cycle(); edges++; end
    checks++;
    if (edges !== 10 || bus.pending !== 1'b0 || bus.count !== 0) begin
      errors++;
      $display("FAIL mid_period edges=%0d pending=%b count=%0d expected 10/0/0", edges, bus.pending, bus.count);
    end
    for (int k = 1; k <= 8; k++) begin
      cycle();
      checks++;
      if (bus.count !== WIDTH'(k % 4) || bus.tick !== ((k % 4) == 0)) begin
        errors++;
        $display("FAIL mid_newN k=%0d count=%0d tick=%b expected %0d/%b", k, bus.count, bus.tick, k % 4, (k % 4) == 0);
      end
    end
  endtask

  task automatic test_pulse();
    int guard = 0;
    do_load(3, 1'b1);
    while (!bus.tick && guard < 10) begin cycle(); guard++; end
    checks++;
    if (!bus.tick || bus.clk_div !== 1'b1) begin
      errors++;
      $display("FAIL pulse_first tick=%b clk_div=%b expected 1/1", bus.tick, bus.clk_div);
    end
    for (int k = 1; k <= 9; k++) begin
      cycle();
      checks++;
      if (bus.count !== WIDTH'(k % 3) || bus.tick !== ((k % 3) == 0) || bus.clk_div !== bus.tick) begin
        errors++;
        $display("FAIL pulse_train k=%0d count=%0d tick=%b clk_div=%b expected %0d/%b/%b",
                 k, bus.count, bus.tick, bus.clk_div, k % 3, (k % 3) == 0, (k % 3) == 0);
      end
    end
  endtask

  task automatic test_invalid();
    int guard = 0;
    do_load(1, 1'b0);
    checks++;
    if (bus.err !== 1'b1 || bus.pending !== 1'b0) begin
      errors++; $display("FAIL inv1 err=%b pending=%b expected 1/0", bus.err, bus.pending);
    end
    cycle();
    checks++;
    if (bus.err !== 1'b0) begin errors++; $display("FAIL inv1_clear err=%b expected 0", bus.err); end
    do_load(0, 1'b0);
    checks++;
    if (bus.err !== 1'b1 || dvec !== mvec()) begin
      errors++; $display("FAIL inv0 err=%b outputs=%h expected err=1 model=%h", bus.err, dvec, mvec());
    end
    while (bus.count !== 0 && guard < 10) begin cycle(); guard++; end
    do_load(7, 1'b0);
    do_load(0, 1'b1);
    checks++;
    if (bus.err !== 1'b1 || bus.pending !== 1'b1) begin
      errors++; $display("FAIL inv_keep err=%b pending=%b expected 1/1", bus.err, bus.pending);
    end
    for (int i = 0; i < 9; i++) cycle();
    checks++;
    if (dvec !== mvec() || m_div !== 7) begin
      errors++; $display("FAIL inv_model outputs=%h expected=%h", dvec, mvec());
    end
  endtask

  task automatic test_load_on_wrap();
    int guard = 0, edges = 0;
    while (bus.count !== 6 && guard < 20) begin cycle(); guard++; end
    do_load(6, 1'b0);
    checks++;
    if (bus.tick !== 1'b1 || bus.count !== 0 || bus.pending !== 1'b0) begin
      errors++;
      $display("FAIL wrap_bypass tick=%b count=%0d pending=%b expected 1/0/0", bus.tick, bus.count, bus.pending);
    end
    do begin cycle(); edges++; end while (!bus.tick && edges < 20);
    checks++;
    if (edges !== 6) begin errors++; $display("FAIL wrap_newN period=%0d expected=6", edges); end
  endtask

  task automatic test_async_clear();
    bus.en = 1'b0;
    do_load(10, 1'b0);
    bus.en = 1'b1;
    for (int i = 0; i < 7; i++) cycle();
    checks++;
    if (bus.count !== 7) begin errors++; $display("FAIL clr_setup count=%0d expected=7", bus.count); end
    #2 clr = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dvec !== '0) begin errors++; $display("FAIL clr_async outputs=%h expected=0", dvec); end
    cycle();
    clr = 1'b1;
    cycle();
    checks++;
    if (bus.count !== 1 || dvec !== mvec()) begin
      errors++; $display("FAIL clr_resume outputs=%h expected=%h", dvec, mvec());
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 3000; i++) begin
      bus.en        = ($urandom_range(0, 9) != 0);
      bus.load      = ($urandom_range(0, 7) == 0);
      bus.div_value = WIDTH'($urandom_range(0, 12));
      bus.mode_in   = 1'($urandom_range(0, 1));
      cycle();
      if (dvec !== mvec()) begin
        if (bad == 0) $display("FAIL random_first i=%0d outputs=%h expected=%h", i, dvec, mvec());
        bad++;
      end
    end
    bus.load = 1'b0;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL random_model mismatches=%0d expected=0", bad); end
  endtask

  initial begin
    bus.en = 1'b0; bus.load = 1'b0; bus.div_value = '0; bus.mode_in = 1'b0;
    model_reset();
    test_reset();
    test_default();
    test_odd();
    test_midchange();
    test_pulse();
    test_invalid();
    test_load_on_wrap();
    test_async_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/modulo_divisor_frequencia_prog.md
Name: modulo_divisor_frequencia_prog

Overview:
Programmable synchronous frequency divider and tick generator; successor to the fixed ripple T-flip-flop divider chain. A single WIDTH-bit counter divides clk by a runtime divisor N. It produces either a near-50% square wave or a one-cycle pulse on clk_div, plus a one-cycle tick at every period wrap. Divisor and mode changes are glitch-free: they are applied only at a period boundary or while the counter is stopped. The block sits between the board clock and the display/timing logic that previously used the fixed divider taps.

Parameters:
WIDTH, 20, counter and divisor width in bits (max N = 2^WIDTH-1)
DEFAULT_DIV, 16384, divisor loaded at reset (must be >= 2 and < 2^WIDTH)
DEFAULT_MODE, 0, output mode at reset (0 = square, 1 = pulse)

Ports:
clk  input  1  system clock, rising edge
clr  input  1  asynchronous reset, active-low
en  input  1  count enable; 0 = counter holds
load  input  1  one-cycle request to stage div_value/mode_in
div_value  input  WIDTH  requested divisor N
mode_in  input  1  requested output mode
clk_div  output  1  divided clock (registered)
tick  output  1  one-cycle pulse per period (registered)
count  output  WIDTH  current counter value
pending  output  1  a staged divisor/mode awaits application
err  output  1  one-cycle flag: load rejected

Behaviour:
- Reset (clr=0, async, dominates everything): cnt=0, div_reg=DEFAULT_DIV, mode_reg=DEFAULT_MODE, pend=0, clk_div=0, tick=0, err=0. Reset asserted mid-period clears all state immediately. Counting resumes from 0 on the first enabled edge after clr is released.
- Counting (en=1): if cnt==N-1, then cnt<=0 and tick<=1 (this is a "wrap edge"). Otherwise cnt<=cnt+1 and tick<=0. Tick period = N clk cycles.
- en=0: cnt holds; tick<=0; clk_div holds.
- Square mode (mode_reg=0): L=floor(N/2). clk_div and cnt update together so that clk_div==(cnt>=L) always holds. Low phase = L cycles, high phase = N-L cycles (odd N: high one cycle longer). clk_div rises when cnt becomes L and falls when cnt wraps to 0.
- Pulse mode (mode_reg=1): clk_div equals tick.
- Staging: on load=1 with div_value>=2, the block captures pend_div<=div_value and pend_mode<=mode_in, and sets pend<=1. A later load overwrites the staged value (last-wins).
- Rejected load: load=1 with div_value<2 leaves the staged value and pend unchanged, and sets err<=1 for exactly one cycle. In every other cycle err<=0.
- Apply on a wrap edge with pend=1: div_reg<=pend_div, mode_reg<=pend_mode, pend<=0. The new N governs the very next period.
- Apply while en=0 with pend=1: the staged values are applied on the next edge. That edge also sets cnt<=0 and clk_div<=0.
- Simultaneous valid load and wrap edge: the incoming div_value/mode_in bypass staging and go directly into div_reg/mode_reg; pend<=0.
- Simultaneous valid load and en=0: same bypass as above; cnt<=0, clk_div<=0.
- No other path changes div_reg or mode_reg. cnt never exceeds N-1.
- Outputs clk_div and tick are registered: no combinational path from any input to any output.
- count mirrors cnt.

Test Plan:
- Reset: hold clr=0 with en=1 toggling -> clk_div=0, tick=0, count=0, pending=0. Release with en=1 -> tick every 16384 cycles; clk_div low for 8192 cycles, then high for 8192 cycles.
- Odd divisor: load div_value=5, mode_in=0 while en=0, then en=1 -> clk_div pattern 0,0,1,1,1 repeating; tick high when count returns to 0, every 5 cycles.
- Mid-period change: N=10 running, load div_value=4 at count=3 -> pending=1. Count runs to 9, wraps, then 0..3 repeating; pending drops at the wrap edge. The period containing the load is exactly 10 cycles.
- Pulse mode: load div_value=3, mode_in=1 -> after the next wrap, clk_div is a one-cycle pulse every 3 cycles, coincident with tick.
- Invalid load: load div_value=1 (and separately 0) -> err high for one cycle, pending unchanged, divisor unchanged.
- Edge cases: valid load on the same edge as a wrap -> new N used immediately, pending=0. Assert clr at count=7 of N=10 -> all outputs cleared asynchronously, before the next clk edge.
